axis_packet_arbiter: RTL
========================

Name: axis_packet_arbiter

Overview:
Round-robin arbiter that shares one AXI4-Stream output among NUM_IN AXI4-Stream sources (CSI-2 packet streams from per-lane or per-virtual-channel front ends). A source holds the grant for a whole packet, from first beat to the beat with tlast. Beats never interleave. A one-entry registered output slice decouples downstream backpressure. A packet counter and grant status support debug.

Parameters:
DATA_W, 32, data width of every stream
NUM_IN, 4, number of source ports (legal range 2..8)
ID_W, 2, width of grant_id; must equal clog2(NUM_IN)

Ports:
clk  input  1  clock; all logic is on the rising edge
reset  input  1  synchronous, active-low reset
s_tvalid  input  NUM_IN  per-source beat valid
s_tready  output  NUM_IN  per-source ready
s_tdata  input  NUM_IN*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
s_tuser  input  NUM_IN  per-source tuser (start of frame)
s_tlast  input  NUM_IN  per-source end of packet
m_tvalid  output  1  output beat valid (registered)
m_tready  input  1  downstream ready
m_tdata  output  DATA_W  output data (registered)
m_tuser  output  1  output tuser (registered)
m_tlast  output  1  output tlast (registered)
grant_id  output  ID_W  index of the granted source; meaningful only while busy=1
busy  output  1  high while a packet is in progress (state XFER)
pkt_count  output  16  count of completed packets accepted from sources; wraps 0xFFFF->0

Behaviour:
- Reset: clk and reset are a single clock domain; reset is synchronous, active-low.
  - While reset=0, at every clk edge: state=IDLE, rr_ptr=0, grant_id=0, busy=0, pkt_count=0, m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0.
  - s_tready is combinationally 0 while reset=0.
  - Reset mid-packet discards the partial packet and any beat held in the output register.
- State IDLE:
  - s_tready is all 0.
  - If any s_tvalid=1, pick the first set index searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_IN.
  - Register grant_id to that index and move to XFER at the next edge.
  - s_tvalid is sampled only in that cycle; a source that drops valid before the grant is not chosen.
- State XFER:
  - s_tready[grant_id] = !m_tvalid || m_tready; all other s_tready bits are 0.
  - Beat accept: s_tvalid[grant_id] && s_tready[grant_id].
  - On accept, the output register loads tdata/tuser/tlast from the granted source and sets m_tvalid=1.
  - Source-to-output latency is exactly 1 cycle.
  - Accepted beat with tlast=1: next edge sets state=IDLE, rr_ptr=(grant_id+1) mod NUM_IN, pkt_count+1.
  - The granted source dropping tvalid mid-packet does not release the grant; the arbiter waits indefinitely. No timeout.
- Output register:
  - Clears m_tvalid when m_tvalid && m_tready and no new load occurs that cycle.
  - A simultaneous drain and load replaces the beat; sustained throughput is 1 beat/cycle.
  - m_tdata, m_tuser and m_tlast are stable while m_tvalid && !m_tready.
- Packet boundaries:
  - One IDLE arbitration cycle separates consecutive packets.
  - The last beat may still sit in the output register during that arbitration.
  - A single-beat packet (tlast on the first beat) is legal.
- Outputs and pass-through:
  - busy = (state==XFER).
  - tuser is passed through per beat and never used by the arbitration.

Test Plan:
1. Hold reset=0 for 3 cycles with all s_tvalid=1 -> s_tready=0000, m_tvalid=0, busy=0, pkt_count=0, grant_id=0 throughout.
2. Source 2 only sends 0xA0, 0xA1, 0xA2 (tlast on 0xA2, tuser on 0xA0), m_tready=1 -> one IDLE cycle, then busy=1 and grant_id=2. Each beat appears on m_tdata 1 cycle after acceptance with m_tuser/m_tlast aligned. pkt_count=1, and the next arbitration starts its search at index 3.
3. All 4 sources continuously valid with 2-beat packets, m_tready=1 -> grant order 0,1,2,3,0,1, no interleaving, pkt_count=6 after six packets, 3 cycles per packet.
4. m_tready=0 for 5 cycles during beat 2 of a 4-beat packet -> m_tdata held constant, s_tready[grant]=0 after the register fills. Output sequence equals input sequence with no loss or duplication.
5. Granted source 1 drops s_tvalid for 3 cycles mid-packet while sources 0 and 3 are valid -> grant_id stays 1 and busy stays 1, and the packet completes before source 3 is granted.
6. reset=0 for one cycle after beat 2 of a 4-beat packet from source 3 -> next edge m_tvalid=0, busy=0, pkt_count=0. After release, with sources 0 and 3 valid, source 0 is granted first.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
// Round-robin AXI4-Stream packet arbiter: NUM_IN sources share one output,
// and a source keeps the grant from its first beat through its tlast beat.
module axis_packet_arbiter #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4,
  parameter int ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        s_tvalid,
  output logic [NUM_IN-1:0]        s_tready,
  input  logic [NUM_IN*DATA_W-1:0] s_tdata,
  input  logic [NUM_IN-1:0]        s_tuser,
  input  logic [NUM_IN-1:0]        s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tuser,
  output logic                     m_tlast,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [15:0]              pkt_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t            state_r;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W-1:0]   grant_id_r;
  logic [15:0]       pkt_count_r;
  logic              m_tvalid_r;
  logic [DATA_W-1:0] m_tdata_r;
  logic              m_tuser_r;
  logic              m_tlast_r;

  logic [DATA_W-1:0] src_data_s [NUM_IN];
  logic [ID_W-1:0]   pick_idx_s;
  logic              pick_found_s;
  logic [ID_W-1:0]   scan_idx_s;
  int                scan_pos_s;
  logic [ID_W-1:0]   next_ptr_s;
  logic              g_tvalid_s;
  logic [DATA_W-1:0] g_tdata_s;
  logic              g_tuser_s;
  logic              g_tlast_s;
  logic              out_ready_s;
  logic              accept_s;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
    assign src_data_s[gi] = s_tdata[gi*DATA_W +: DATA_W];
  end

  // First valid source at or after rr_ptr_r, wrapping modulo NUM_IN.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {ID_W{1'b0}};
    scan_pos_s   = 0;
    scan_idx_s   = {ID_W{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      scan_pos_s   = int'(rr_ptr_r) + k;
      scan_pos_s   = (scan_pos_s >= NUM_IN) ? (scan_pos_s - NUM_IN) : scan_pos_s;
      scan_idx_s   = ID_W'(scan_pos_s);
      pick_idx_s   = (!pick_found_s && s_tvalid[scan_idx_s]) ? scan_idx_s : pick_idx_s;
      pick_found_s = pick_found_s | s_tvalid[scan_idx_s];
    end
  end

  assign g_tvalid_s  = s_tvalid[grant_id_r];
  assign g_tdata_s   = src_data_s[grant_id_r];
  assign g_tuser_s   = s_tuser[grant_id_r];
  assign g_tlast_s   = s_tlast[grant_id_r];
  assign out_ready_s = !m_tvalid_r || m_tready;
  assign accept_s    = (state_r == XFER) && g_tvalid_s && out_ready_s;
  assign next_ptr_s  = (int'(grant_id_r) == NUM_IN - 1) ? {ID_W{1'b0}} : (grant_id_r + 1'b1);

  // Only the granted source sees ready, and only while the output slice can take a beat.
  always_comb begin
    s_tready = {NUM_IN{1'b0}};
    if (reset && (state_r == XFER)) begin
      s_tready[grant_id_r] = out_ready_s;
    end else begin
      s_tready = {NUM_IN{1'b0}};
    end
  end

  // Arbitration FSM, packet counter and the one-entry output slice.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {ID_W{1'b0}};
      grant_id_r  <= {ID_W{1'b0}};
      pkt_count_r <= 16'd0;
      m_tvalid_r  <= 1'b0;
      m_tdata_r   <= {DATA_W{1'b0}};
      m_tuser_r   <= 1'b0;
      m_tlast_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            grant_id_r <= pick_idx_s;
            state_r    <= XFER;
          end
        end
        XFER: begin
          if (accept_s && g_tlast_s) begin
            state_r     <= IDLE;
            rr_ptr_r    <= next_ptr_s;
            pkt_count_r <= pkt_count_r + 16'd1;
          end
        end
        default: state_r <= IDLE;
      endcase

      // A load in the same cycle as a drain simply replaces the beat.
      if (accept_s) begin
        m_tvalid_r <= 1'b1;
        m_tdata_r  <= g_tdata_s;
        m_tuser_r  <= g_tuser_s;
        m_tlast_r  <= g_tlast_s;
      end else if (m_tready) begin
        m_tvalid_r <= 1'b0;
      end
    end
  end

  assign m_tvalid  = m_tvalid_r;
  assign m_tdata   = m_tdata_r;
  assign m_tuser   = m_tuser_r;
  assign m_tlast   = m_tlast_r;
  assign grant_id  = grant_id_r;
  assign busy      = (state_r == XFER);
  assign pkt_count = pkt_count_r;

endmodule
